// File: rtl/sdram_arbiter.sv
// Single-port memory arbiter: serializes single-word USB and GBA requests onto one
// memory command port, GBA first, with a starvation counter guaranteeing USB progress.
module sdram_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic              usb_wr,
  input  logic [DATA_W-1:0] usb_wr_data,
  output logic              usb_wr_ready,
  input  logic              usb_rd,
  output logic [DATA_W-1:0] usb_rd_data,
  output logic              usb_rd_valid,
  input  logic              gba_req,
  input  logic              gba_we,
  input  logic [ADDR_W-1:0] gba_addr,
  input  logic [DATA_W-1:0] gba_wdata,
  output logic              gba_ack,
  output logic [DATA_W-1:0] gba_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_usb,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             usb_pend, starved, take_usb, take_gba, own_usb_busy;

  assign usb_pend     = usb_wr | usb_rd;
  assign starved      = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign busy         = (state != IDLE);
  assign own_usb_busy = busy & grant_usb;

  assign mem_req      = (state == ISSUE);
  assign gba_ack      = (state == RESP) & ~grant_usb;
  assign usb_wr_ready = (state == RESP) & grant_usb & mem_we;
  assign usb_rd_valid = (state == RESP) & grant_usb & ~mem_we & usb_rd;

  always_comb begin
    state_nxt = state;
    take_usb  = 1'b0;
    take_gba  = 1'b0;
    case (state)
      IDLE: begin
        if (usb_pend && starved) take_usb = 1'b1;
        else if (gba_req)        take_gba = 1'b1;
        else if (usb_pend)       take_usb = 1'b1;
        if (take_usb || take_gba) state_nxt = ISSUE;
      end
      ISSUE:   if (mem_ready) state_nxt = mem_we ? RESP : WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_nxt = RESP;
      RESP:    if (!grant_usb || mem_we || usb_rd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // USB waiting on its own transaction is not starvation, so the counter only
  // advances while USB is pending and something else owns (or wins) the port.
  always_comb begin
    starve_nxt = starve_cnt;
    if (take_usb)
      starve_nxt = '0;
    else if (usb_pend && !own_usb_busy && !starved)
      starve_nxt = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      grant_usb   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      usb_rd_data <= '0;
      gba_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (take_usb) begin
        grant_usb <= 1'b1;
        mem_we    <= usb_wr;
        mem_addr  <= usb_addr;
        mem_wdata <= usb_wr_data;
      end else if (take_gba) begin
        grant_usb <= 1'b0;
        mem_we    <= gba_we;
        mem_addr  <= gba_addr;
        mem_wdata <= gba_wdata;
      end
      if (state == WAIT_RD && mem_rvalid) begin
        if (grant_usb) usb_rd_data <= mem_rdata;
        else           gba_rdata   <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_sdram_arbiter;
  localparam int unsigned LIM = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] usb_addr = '0, usb_wr_data = '0, gba_addr = '0, gba_wdata = '0, mem_rdata = '0;
  logic        usb_wr = 1'b0, usb_rd = 1'b0, gba_req = 1'b0, gba_we = 1'b0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic        usb_wr_ready, usb_rd_valid, gba_ack, mem_req, mem_we, grant_usb, busy;
  logic [31:0] usb_rd_data, gba_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .usb_addr(usb_addr), .usb_wr(usb_wr), .usb_wr_data(usb_wr_data), .usb_wr_ready(usb_wr_ready),
    .usb_rd(usb_rd), .usb_rd_data(usb_rd_data), .usb_rd_valid(usb_rd_valid),
    .gba_req(gba_req), .gba_we(gba_we), .gba_addr(gba_addr), .gba_wdata(gba_wdata),
    .gba_ack(gba_ack), .gba_rdata(gba_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .grant_usb(grant_usb), .busy(busy)
  );

  int checks = 0, failures = 0;
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction described by flags (accepted, done).
  bit          m_active = 0, m_usb = 0, m_we = 0, m_acc = 0, m_done = 0;
  bit [31:0]   m_addr = 0, m_wdata = 0, m_usb_rdata = 0, m_gba_rdata = 0;
  int unsigned m_starve = 0;
  bit          ev_gba = 0, ev_usbw = 0, ev_usbr = 0;
  bit          mpend, mto_usb, mto_gba;
  bit [31:0]   mem_arr [bit [31:0]];

  always @(posedge clk) begin
    cyc++;
    ev_gba = 0; ev_usbw = 0; ev_usbr = 0;
    if (!rst_n) begin
      m_active = 0; m_usb = 0; m_we = 0; m_acc = 0; m_done = 0;
      m_addr = 0; m_wdata = 0; m_usb_rdata = 0; m_gba_rdata = 0; m_starve = 0;
    end else begin
      mpend = usb_wr || usb_rd;
      if (!m_active) begin
        mto_usb = mpend && (m_starve >= LIM || !gba_req);
        mto_gba = !mto_usb && gba_req;
        if (mto_usb) m_starve = 0;
        else if (mpend && m_starve < LIM) m_starve++;
        if (mto_usb) begin
          m_active = 1; m_usb = 1; m_we = usb_wr; m_addr = usb_addr; m_wdata = usb_wr_data;
        end else if (mto_gba) begin
          m_active = 1; m_usb = 0; m_we = gba_we; m_addr = gba_addr; m_wdata = gba_wdata;
        end
        m_acc = 0; m_done = 0;
      end else begin
        if (mpend && !m_usb && m_starve < LIM) m_starve++;
        if (!m_acc) begin
          if (mem_ready) begin
            m_acc = 1;
            if (m_we) begin m_done = 1; mem_arr[m_addr] = m_wdata; end
          end
        end else if (!m_done) begin
          if (mem_rvalid) begin
            m_done = 1;
            if (m_usb) m_usb_rdata = mem_rdata; else m_gba_rdata = mem_rdata;
          end
        end else if (!m_usb) begin
          ev_gba = 1; m_active = 0;
        end else if (m_we) begin
          ev_usbw = 1; m_active = 0;
        end else if (usb_rd) begin
          ev_usbr = 1; m_active = 0;
        end
      end
    end
  end

  // Memory responder, driven from the model's view of the outstanding transaction.
  int          rdy_pct = 100, fix_delay = 0, rv_wait = 0, rv_delay = 0;
  bit          force_en = 0, spur_en = 0, inject_rv = 0;
  bit [31:0]   force_val = 0;

  always begin
    @(posedge clk); #2;
    mem_ready = ($urandom_range(99) < rdy_pct);
    if (m_active && m_acc && !m_done && !m_we) begin
      mem_rvalid = (rv_wait >= rv_delay);
      mem_rdata  = force_en ? force_val :
                   (mem_arr.exists(m_addr) ? mem_arr[m_addr] : (m_addr ^ 32'hA5A5_0000));
      rv_wait++;
    end else begin
      rv_wait    = 0;
      rv_delay   = (fix_delay >= 0) ? fix_delay : int'($urandom_range(4));
      mem_rvalid = inject_rv || (spur_en && $urandom_range(7) == 0);
      mem_rdata  = $urandom;
    end
  end

  bit e_resp;
  always @(negedge clk) begin
    if (rst_n) begin
      e_resp = m_active && m_done;
      chk("busy", busy, m_active);
      chk("mem_req", mem_req, m_active && !m_acc);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_active && !m_acc && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("grant_usb", grant_usb, m_usb);
      chk("gba_ack", gba_ack, e_resp && !m_usb);
      chk("usb_wr_ready", usb_wr_ready, e_resp && m_usb && m_we);
      chk("usb_rd_valid", usb_rd_valid, e_resp && m_usb && !m_we && usb_rd);
      chk("usb_rd_data", usb_rd_data, m_usb_rdata);
      chk("gba_rdata", gba_rdata, m_gba_rdata);
    end else begin
      chk("rst_outs", {busy, mem_req, mem_we, grant_usb, gba_ack, usb_wr_ready, usb_rd_valid}, 0);
      chk("rst_data", {mem_addr, mem_wdata} | {usb_rd_data, gba_rdata}, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int unsigned t[3];
  int unsigned start, tack, gba_acks;
  bit          ok, seen;
  bit [31:0]   seen_addr[$];
  bit [31:0]   seen_data[$];
  bit          usb_rd_req = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("reset_mem_req", mem_req, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Lone USB writes, 3 cycles apart.
    for (int i = 0; i < 3; i++) begin
      usb_addr = 32'h100 + 32'(4 * i); usb_wr_data = 32'h8C8D_8E8F; usb_wr = 1'b1;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_req && mem_ready) begin seen_addr.push_back(mem_addr); seen_data.push_back(mem_wdata); end
        if (usb_wr_ready) begin ok = 1; t[i] = cyc; break; end
      end
      chk("usbw_pulse", ok, 1);
      tick();
      if (i == 2) usb_wr = 1'b0;
    end
    chk("usbw_gap01", t[1] - t[0], 3);
    chk("usbw_gap12", t[2] - t[1], 3);
    chk("usbw_count", seen_addr.size(), 3);
    if (seen_addr.size() == 3) begin
      chk("usbw_addr0", seen_addr[0], 32'h100);
      chk("usbw_addr1", seen_addr[1], 32'h104);
      chk("usbw_addr2", seen_addr[2], 32'h108);
      chk("usbw_data", seen_data[2], 32'h8C8D_8E8F);
    end
    @(negedge clk);
    chk("usbw_ready_off", usb_wr_ready, 0);

    // Lone GBA read, rvalid 3 cycles after accept.
    tick();
    fix_delay = 2; force_en = 1; force_val = 32'hDEAD_BEEF;
    gba_addr = 32'h0800_0000; gba_we = 1'b0; gba_req = 1'b1; start = cyc;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gba_ack) begin ok = 1; tack = cyc; break; end
    end
    chk("gba_ack_seen", ok, 1);
    chk("gba_rdata_lit", gba_rdata, 32'hDEAD_BEEF);
    chk("gba_rd_latency", tack - start, 5);
    tick(); gba_req = 1'b0;
    @(negedge clk);
    chk("gba_ack_1cyc", gba_ack, 0);

    // Contention: GBA back-to-back reads vs USB write.
    tick();
    force_en = 0; fix_delay = 1;
    gba_addr = 32'h0800_0010; gba_we = 1'b0; gba_req = 1'b1;
    usb_addr = 32'h200; usb_wr_data = 32'h1111_2222; usb_wr = 1'b1;
    gba_acks = 0; ok = 0; seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy && grant_usb && !seen) begin seen = 1; chk("starve_clr", dut.starve_cnt, 0); end
      tick();
      if (ev_gba) begin gba_acks++; gba_addr = gba_addr + 32'h4; end
      if (ev_usbw) begin ok = 1; break; end
    end
    chk("cont_usb_done", ok, 1);
    chk("cont_gba_first", gba_acks, 1);
    usb_wr = 1'b0; gba_req = 1'b0;

    // USB read backpressure.
    tick();
    force_en = 1; force_val = 32'h1234_5678;
    usb_addr = 32'h300; usb_rd = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m_active && m_done) begin ok = 1; break; end
    end
    chk("bp_resp_reached", ok, 1);
    usb_rd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid_low", usb_rd_valid, 0);
      chk("bp_data_held", usb_rd_data, 32'h1234_5678);
      chk("bp_busy", busy, 1);
      tick();
    end
    usb_rd = 1'b1;
    @(negedge clk);
    chk("bp_valid_high", usb_rd_valid, 1);
    tick(); usb_rd = 1'b0;
    @(negedge clk);
    chk("bp_idle", busy, 0);

    // mem_ready low for 20 cycles on a GBA write.
    force_en = 0; rdy_pct = 0;
    tick();
    gba_addr = 32'h0800_0040; gba_wdata = 32'hCAFE_F00D; gba_we = 1'b1; gba_req = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h0800_0040);
      chk("stall_wdata", mem_wdata, 32'hCAFE_F00D);
      chk("stall_no_ack", gba_ack, 0);
      tick();
    end
    rdy_pct = 100;
    ok = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (gba_ack) begin ok = 1; break; end
    end
    chk("stall_ack", ok, 1);
    tick(); gba_req = 1'b0;

    // Reset during WAIT_RD, then a late rvalid.
    fix_delay = 30;
    tick();
    gba_addr = 32'h0800_0080; gba_we = 1'b0; gba_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m_active && m_acc && !m_done) begin ok = 1; break; end
    end
    chk("rst_wait_reached", ok, 1);
    gba_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_async_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1; inject_rv = 1;
    tick(); inject_rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_rv_busy", busy, 0);
      chk("late_rv_ack", gba_ack, 0);
      chk("late_rv_rdata", gba_rdata, 0);
      tick();
    end

    // Randomized traffic.
    fix_delay = -1; spur_en = 1; rdy_pct = 70;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (ev_gba || !gba_req) begin
        if ($urandom_range(99) < 40) begin
          gba_req = 1'b1; gba_we = 1'($urandom_range(1));
          gba_addr = {26'h0, 4'($urandom_range(15)), 2'b00}; gba_wdata = $urandom;
        end else gba_req = 1'b0;
      end
      if (ev_usbw) usb_wr = 1'b0;
      if (ev_usbr) usb_rd_req = 1'b0;
      if (!usb_wr && !usb_rd_req && $urandom_range(99) < 30) begin
        usb_addr = {26'h0, 4'($urandom_range(15)), 2'b00}; usb_wr_data = $urandom;
        case ($urandom_range(9))
          0:       begin usb_wr = 1'b1; usb_rd_req = 1'b1; end
          1,2,3,4: usb_wr = 1'b1;
          default: usb_rd_req = 1'b1;
        endcase
      end
      usb_rd = usb_rd_req &&
               (!(m_active && m_done && m_usb && !m_we) || $urandom_range(99) < 70);
    end
    tick();
    usb_wr = 1'b0; usb_rd = 1'b0; gba_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
